// File: rtl/fifo_pkg.sv
// Shared types and helpers for the first-word-fall-through FIFO.
// Read-side prefetch state encoding plus unsigned count/threshold compares.
package fifo_pkg;

    typedef enum logic [1:0] {
        RD_EMPTY = 2'd0,
        RD_FETCH = 2'd1,
        RD_VALID = 2'd2
    } fifo_rd_state_t;

    function automatic logic cnt_at_least(input logic [31:0] cnt, input logic [31:0] thr);
        return cnt >= thr;
    endfunction

    function automatic logic cnt_at_most(input logic [31:0] cnt, input logic [31:0] thr);
        return cnt <= thr;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: one write port, one read port whose address is registered,
// so data for an address presented before an edge is available after that edge.
module fifo_dpram #(
    parameter int W_A = 4,
    parameter int W_D = 32
) (
    input  logic           clk,
    input  logic           we,
    input  logic [W_A-1:0] wa,
    input  logic [W_D-1:0] wd,
    input  logic [W_A-1:0] ra,
    output logic [W_D-1:0] rq
);

    logic [W_D-1:0] mem [2**W_A];
    logic [W_A-1:0] ra_q;

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        ra_q <= ra;
    end

    assign rq = mem[ra_q];

endmodule

// File: rtl/fifo_fwft.sv
// Synchronous FIFO with first-word-fall-through output, occupancy count and almost flags.
// Define FIFO_ERR_FLAGS_EN to enable the sticky overflow_o/underflow_o error flags.
module fifo_fwft
    import fifo_pkg::*;
#(
    parameter int ADDR_LEN   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n_i,
    input  logic [DATA_WIDTH-1:0] writer_d_i,
    input  logic                  writer_enq_i,
    output logic                  writer_full_o,
    output logic                  writer_alm_full_o,
    output logic [DATA_WIDTH-1:0] reader_q_o,
    input  logic                  reader_deq_i,
    output logic                  reader_empty_o,
    output logic                  reader_alm_empty_o,
    input  logic [ADDR_LEN:0]     alm_full_thresh_i,
    input  logic [ADDR_LEN:0]     alm_empty_thresh_i,
    output logic [ADDR_LEN:0]     count_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    input  logic                  err_clr_i
);

    localparam logic [ADDR_LEN:0] DEPTH_C = {1'b1, {ADDR_LEN{1'b0}}};
    localparam logic [ADDR_LEN:0] ONE_C   = {{ADDR_LEN{1'b0}}, 1'b1};

    logic [ADDR_LEN:0]     wr_ptr, rd_ptr, rd_ptr_next, count_q, count_next;
    logic [DATA_WIDTH-1:0] ram_q, head_q;
    fifo_rd_state_t        rd_state;
    logic                  enq_ok, deq_ok, ram_avail, load;
    logic                  full_q, alm_full_q, empty_q, alm_empty_q;

    // The RAM read address always tracks the next RAM head, so the word behind the
    // output register is already on ram_q and a pop can refill it on the same edge.
    always_comb begin
        enq_ok    = writer_enq_i && !full_q;
        deq_ok    = reader_deq_i && (rd_state == RD_VALID);
        ram_avail = (wr_ptr != rd_ptr);
        load      = 1'b0;
        case (rd_state)
            RD_FETCH: load = 1'b1;
            RD_VALID: load = deq_ok && ram_avail;
            default:  load = 1'b0;
        endcase
        rd_ptr_next = load ? rd_ptr + ONE_C : rd_ptr;
        count_next  = count_q + (enq_ok ? ONE_C : '0) - (deq_ok ? ONE_C : '0);
    end

    fifo_dpram #(.W_A(ADDR_LEN), .W_D(DATA_WIDTH)) u_ram (
        .clk (clk),
        .we  (enq_ok),
        .wa  (wr_ptr[ADDR_LEN-1:0]),
        .wd  (writer_d_i),
        .ra  (rd_ptr_next[ADDR_LEN-1:0]),
        .rq  (ram_q)
    );

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            alm_full_q  <= 1'b0;
            alm_empty_q <= 1'b1;
        end else begin
            if (enq_ok) wr_ptr <= wr_ptr + ONE_C;
            rd_ptr      <= rd_ptr_next;
            count_q     <= count_next;
            full_q      <= (count_next == DEPTH_C);
            alm_full_q  <= cnt_at_least(32'(count_next), 32'(alm_full_thresh_i));
            alm_empty_q <= cnt_at_most(32'(count_next), 32'(alm_empty_thresh_i));
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_state <= RD_EMPTY;
            head_q   <= '0;
            empty_q  <= 1'b1;
        end else begin
            case (rd_state)
                RD_EMPTY: begin
                    if (ram_avail) rd_state <= RD_FETCH;
                end
                RD_FETCH: begin
                    head_q   <= ram_q;
                    empty_q  <= 1'b0;
                    rd_state <= RD_VALID;
                end
                RD_VALID: begin
                    if (deq_ok) begin
                        if (ram_avail) begin
                            head_q <= ram_q;
                        end else begin
                            empty_q  <= 1'b1;
                            rd_state <= RD_EMPTY;
                        end
                    end
                end
                default: begin
                    empty_q  <= 1'b1;
                    rd_state <= RD_EMPTY;
                end
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    // A new error in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (writer_enq_i && full_q)       ovf_q <= 1'b1;
            else if (err_clr_i)               ovf_q <= 1'b0;
            if (reader_deq_i && empty_q)      unf_q <= 1'b1;
            else if (err_clr_i)               unf_q <= 1'b0;
        end
    end

    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign overflow_o     = 1'b0;
    assign underflow_o    = 1'b0;
`endif

    assign writer_full_o      = full_q;
    assign writer_alm_full_o  = alm_full_q;
    assign reader_q_o         = head_q;
    assign reader_empty_o     = empty_q;
    assign reader_alm_empty_o = alm_empty_q;
    assign count_o            = count_q;

endmodule

// File: tb/tb_fifo_fwft.sv
// Self-checking bench for fifo_fwft: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_fwft;

  localparam int AL    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 2 ** AL;

  logic          clk;
  logic          reset_n_i;
  logic [DW-1:0] writer_d_i;
  logic          writer_enq_i;
  logic          writer_full_o;
  logic          writer_alm_full_o;
  logic [DW-1:0] reader_q_o;
  logic          reader_deq_i;
  logic          reader_empty_o;
  logic          reader_alm_empty_o;
  logic [AL:0]   alm_full_thresh_i;
  logic [AL:0]   alm_empty_thresh_i;
  logic [AL:0]   count_o;
  logic          overflow_o;
  logic          underflow_o;
  logic          err_clr_i;

  fifo_fwft #(.ADDR_LEN(AL), .DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .reset_n_i          (reset_n_i),
    .writer_d_i         (writer_d_i),
    .writer_enq_i       (writer_enq_i),
    .writer_full_o      (writer_full_o),
    .writer_alm_full_o  (writer_alm_full_o),
    .reader_q_o         (reader_q_o),
    .reader_deq_i       (reader_deq_i),
    .reader_empty_o     (reader_empty_o),
    .reader_alm_empty_o (reader_alm_empty_o),
    .alm_full_thresh_i  (alm_full_thresh_i),
    .alm_empty_thresh_i (alm_empty_thresh_i),
    .count_o            (count_o),
    .overflow_o         (overflow_o),
    .underflow_o        (underflow_o),
    .err_clr_i          (err_clr_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  logic [DW-1:0] exp_q[$];   // every accepted, not yet popped word, head first
  bit  m_vis;                // head currently presented
  int  m_stage;              // edges spent waiting to present a stored word
  bit  m_ovf, m_unf;
  bit  e_full, e_alm_full, e_alm_empty;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_vis = 0; m_stage = 0; m_ovf = 0; m_unf = 0;
    e_full = 0; e_alm_full = 0; e_alm_empty = 1;
  endtask

  // Applies one rising edge to the model using the inputs sampled before that edge.
  task automatic model_edge(input logic enq, input logic [DW-1:0] d, input logic deq, input logic clr);
    int  pre = exp_q.size();
    bit  full_pre = (pre == DEPTH);
    bit  deq_ok = deq && m_vis;
    bit  enq_ok = enq && !full_pre;
`ifdef FIFO_ERR_FLAGS_EN
    if (enq && full_pre) m_ovf = 1; else if (clr) m_ovf = 0;
    if (deq && !m_vis)   m_unf = 1; else if (clr) m_unf = 0;
`endif
    if (deq_ok) begin
      void'(exp_q.pop_front());
      if (pre - 1 == 0) begin
        m_vis = 0;
        m_stage = 0;
      end
    end else if (!m_vis && pre > 0) begin
      // a stored word reaches the output two edges after the output is idle
      m_stage++;
      if (m_stage == 2) m_vis = 1;
    end
    if (enq_ok) exp_q.push_back(d);
    e_full      = (exp_q.size() == DEPTH);
    e_alm_full  = (exp_q.size() >= int'(alm_full_thresh_i));
    e_alm_empty = (exp_q.size() <= int'(alm_empty_thresh_i));
  endtask

  task automatic check_all();
    chk("count", DW'(count_o), DW'(exp_q.size()));
    chk("full", DW'(writer_full_o), DW'(e_full));
    chk("alm_full", DW'(writer_alm_full_o), DW'(e_alm_full));
    chk("empty", DW'(reader_empty_o), DW'(!m_vis));
    chk("alm_empty", DW'(reader_alm_empty_o), DW'(e_alm_empty));
    chk("overflow", DW'(overflow_o), DW'(m_ovf));
    chk("underflow", DW'(underflow_o), DW'(m_unf));
    if (m_vis) chk("q_data", reader_q_o, exp_q[0]);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic enq, input logic [DW-1:0] d, input logic deq, input logic clr);
    writer_enq_i = enq;
    writer_d_i   = d;
    reader_deq_i = deq;
    err_clr_i    = clr;
    @(posedge clk);
    model_edge(enq, d, deq, clr);
    @(negedge clk);
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() > 0; i++) cycle(1'b0, '0, m_vis, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    reset_n_i    = 1'b0;
    writer_enq_i = 1'b0;
    reader_deq_i = 1'b0;
    err_clr_i    = 1'b0;
    #1;
    chk("rst_count", DW'(count_o), '0);
    chk("rst_full", DW'(writer_full_o), '0);
    chk("rst_alm_full", DW'(writer_alm_full_o), '0);
    chk("rst_empty", DW'(reader_empty_o), 32'd1);
    chk("rst_alm_empty", DW'(reader_alm_empty_o), 32'd1);
    chk("rst_q", reader_q_o, '0);
    chk("rst_overflow", DW'(overflow_o), '0);
    chk("rst_underflow", DW'(underflow_o), '0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n_i = 1'b1;
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n_i          = 1'b0;
    writer_d_i         = '0;
    writer_enq_i       = 1'b0;
    reader_deq_i       = 1'b0;
    err_clr_i          = 1'b0;
    alm_full_thresh_i  = 5'd12;
    alm_empty_thresh_i = 5'd3;
    model_reset();
    @(negedge clk);
    do_reset();

    // first word latency
    cycle(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    chk("t1_count_n", DW'(count_o), 32'd1);
    chk("t1_empty_n", DW'(reader_empty_o), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("t1_empty_n1", DW'(reader_empty_o), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("t1_empty_n2", DW'(reader_empty_o), 32'd0);
    chk("t1_q", reader_q_o, 32'hA5A5_0001);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("t1_count_pop", DW'(count_o), 32'd0);

    // fill to full with threshold tracking, overflow, in-order drain
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, DW'(i), 1'b0, 1'b0);
      chk("t3_alm_full", DW'(writer_alm_full_o), DW'((i + 1) >= 12));
      chk("t3_alm_empty", DW'(reader_alm_empty_o), DW'((i + 1) <= 3));
    end
    chk("t2_full", DW'(writer_full_o), 32'd1);
    chk("t2_count16", DW'(count_o), 32'd16);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("t2_count_after_drop", DW'(count_o), 32'd16);
`ifdef FIFO_ERR_FLAGS_EN
    chk("t2_overflow", DW'(overflow_o), 32'd1);
`endif
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("t2_overflow_clr", DW'(overflow_o), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_pop_data", reader_q_o, DW'(i));
      cycle(1'b0, '0, 1'b1, 1'b0);
    end
    chk("t2_empty", DW'(reader_empty_o), 32'd1);
    chk("t2_count0", DW'(count_o), 32'd0);

    // steady streaming at count 8
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'h1000 + DW'(i), 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 32'h2000 + DW'(i), 1'b1, 1'b0);
      chk("t4_count8", DW'(count_o), 32'd8);
      chk("t4_no_gap", DW'(reader_empty_o), 32'd0);
    end
    drain();

    // full with simultaneous enq/deq, then underflow and its clear
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h3000 + DW'(i), 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 32'h3FFF, 1'b1, 1'b0);
    chk("t5_count15", DW'(count_o), 32'd15);
    chk("t5_head", reader_q_o, 32'h3001);
    cycle(1'b0, '0, 1'b0, 1'b1);
    drain();
    cycle(1'b0, '0, 1'b1, 1'b0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("t5_underflow", DW'(underflow_o), 32'd1);
`endif
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("t5_underflow_clr", DW'(underflow_o), 32'd0);

    // reset mid-transfer
    for (int i = 0; i < 9; i++) cycle(1'b1, 32'h4000 + DW'(i), 1'b0, 1'b0);
    chk("t6_count9", DW'(count_o), 32'd9);
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h5000 + DW'(i), 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("t6_resume_head", reader_q_o, 32'h5000);
    drain();

    // randomized traffic with shifting bias and thresholds
    for (int i = 0; i < 3000; i++) begin
      int enq_pct;
      if (i % 250 == 0) begin
        alm_full_thresh_i  = 5'($urandom_range(1, 20));
        alm_empty_thresh_i = 5'($urandom_range(0, 17));
      end
      enq_pct = ((i / 300) % 2 == 0) ? 70 : 30;
      cycle($urandom_range(0, 99) < enq_pct, $urandom,
            $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
